// File: rtl/sprite_mover_if.sv
// Control/pixel bundle between the ready/move control FSM, sprite_mover and the VGA adapter.
// The control FSM is the master: it drives start/move and consumes stop/busy.
interface sprite_mover_if;
  logic       start;
  logic       move;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       stop;
  logic       busy;

  modport master (
    output start, move,
    input  x_out, y_out, colour, plot, stop, busy
  );

  modport slave (
    input  start, move,
    output x_out, y_out, colour, plot, stop, busy
  );
endinterface

// File: rtl/sprite_mover.sv
// Bouncing BOXxBOX square animator: each tick it erases the square, moves it one pixel
// diagonally (reflecting off the grid walls) and redraws it as a one-pixel-per-cycle stream.
module sprite_mover #(
  parameter int          X_MAX    = 160,
  parameter int          Y_MAX    = 120,
  parameter int          BOX      = 4,
  parameter int          TICK_DIV = 833333,
  parameter int          X_INIT   = 0,
  parameter int          Y_INIT   = 0,
  parameter logic [2:0]  COLOUR   = 3'b111
) (
  input  logic           clk,
  input  logic           resetn,
  sprite_mover_if.slave  bus
);

  localparam int LB = $clog2(BOX);
  localparam int CW = 2 * LB;
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [7:0]    X_HI      = 8'(X_MAX - BOX);
  localparam logic [6:0]    Y_HI      = 7'(Y_MAX - BOX);
  localparam logic [CW-1:0] PIX_LAST  = {CW{1'b1}};
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_ERASE  = 2'd1,
    S_UPDATE = 2'd2,
    S_DRAW   = 2'd3
  } state_e;

  // Returns {new_dir, new_pos}: reflect at a wall, otherwise step by one.
  function automatic logic [8:0] bounce_x(input logic [7:0] p, input logic d);
    if (d && (p == X_HI)) begin
      bounce_x = {1'b0, p - 8'd1};
    end else if (!d && (p == 8'd0)) begin
      bounce_x = {1'b1, p + 8'd1};
    end else if (d) begin
      bounce_x = {1'b1, p + 8'd1};
    end else begin
      bounce_x = {1'b0, p - 8'd1};
    end
  endfunction

  function automatic logic [7:0] bounce_y(input logic [6:0] p, input logic d);
    if (d && (p == Y_HI)) begin
      bounce_y = {1'b0, p - 7'd1};
    end else if (!d && (p == 7'd0)) begin
      bounce_y = {1'b1, p + 7'd1};
    end else if (d) begin
      bounce_y = {1'b1, p + 7'd1};
    end else begin
      bounce_y = {1'b0, p - 7'd1};
    end
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      px_q, px_d;
  logic [6:0]      py_q, py_d;
  logic            dx_q, dx_d;
  logic            dy_q, dy_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      x_out_q, x_out_d;
  logic [6:0]      y_out_q, y_out_d;
  logic [2:0]      colour_q, colour_d;
  logic            plot_q, plot_d;
  logic            stop_q, stop_d;
  logic            busy_q, busy_d;

  logic            emit_s;
  logic [CW-1:0]   emit_idx_s;
  logic [7:0]      base_x_s;
  logic [6:0]      base_y_s;
  logic [2:0]      emit_col_s;
  logic [8:0]      nxt_x_s;
  logic [7:0]      nxt_y_s;

  // Next-state and next-output logic; outputs are computed for the cycle being entered
  // so the registered pixel lines up with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    tick_d     = tick_q;
    cnt_d      = cnt_q;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    stop_d     = 1'b0;
    emit_s     = 1'b0;
    emit_idx_s = '0;
    base_x_s   = px_q;
    base_y_s   = py_q;
    emit_col_s = 3'b000;
    nxt_x_s    = bounce_x(px_q, dx_q);
    nxt_y_s    = bounce_y(py_q, dy_q);

    case (state_q)
      S_WAIT: begin
        if (bus.start) begin
          px_d   = 8'(X_INIT);
          py_d   = 7'(Y_INIT);
          dx_d   = 1'b1;
          dy_d   = 1'b1;
          tick_d = '0;
        end else if (bus.move) begin
          if (tick_q == TICK_LAST) begin
            tick_d     = '0;
            state_d    = S_ERASE;
            cnt_d      = '0;
            emit_s     = 1'b1;
            emit_idx_s = '0;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end else begin
          tick_d = tick_q;
        end
      end
      S_ERASE: begin
        if (cnt_q == PIX_LAST) begin
          state_d = S_UPDATE;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          emit_s     = 1'b1;
          emit_idx_s = cnt_q + CW'(1);
        end
      end
      S_UPDATE: begin
        // The first draw pixel leaves in the same edge, so it uses the new position.
        dx_d       = nxt_x_s[8];
        px_d       = nxt_x_s[7:0];
        dy_d       = nxt_y_s[7];
        py_d       = nxt_y_s[6:0];
        state_d    = S_DRAW;
        cnt_d      = '0;
        emit_s     = 1'b1;
        emit_idx_s = '0;
        base_x_s   = nxt_x_s[7:0];
        base_y_s   = nxt_y_s[6:0];
        emit_col_s = COLOUR;
        stop_d     = dy_q && (nxt_y_s[6:0] == Y_HI);
      end
      S_DRAW: begin
        emit_col_s = COLOUR;
        if (cnt_q == PIX_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          emit_s     = 1'b1;
          emit_idx_s = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase

    if (emit_s) begin
      plot_d   = 1'b1;
      x_out_d  = base_x_s + 8'(emit_idx_s[LB-1:0]);
      y_out_d  = base_y_s + 7'(emit_idx_s[CW-1:LB]);
      colour_d = emit_col_s;
    end else begin
      plot_d = 1'b0;
    end

    busy_d = (state_d != S_WAIT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_WAIT;
      px_q     <= 8'd0;
      py_q     <= 7'd0;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      tick_q   <= '0;
      cnt_q    <= '0;
      x_out_q  <= 8'd0;
      y_out_q  <= 7'd0;
      colour_q <= 3'b000;
      plot_q   <= 1'b0;
      stop_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      stop_q   <= stop_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.x_out  = x_out_q;
  assign bus.y_out  = y_out_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.stop   = stop_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: a 160x120 instance and a 16x16 instance (for the corner bounce),
// checked against a position/direction model that follows the bounce rules directly.
module tb_sprite_mover;
  localparam int BOX = 4;
  localparam int TD  = 4;

  logic clk = 1'b0;
  logic resetn;
  logic drv_start, drv_move;
  logic sel;

  always #5 clk = ~clk;

  sprite_mover_if sif_a();
  sprite_mover_if sif_b();

  assign sif_a.start = sel ? 1'b0 : drv_start;
  assign sif_a.move  = sel ? 1'b0 : drv_move;
  assign sif_b.start = sel ? drv_start : 1'b0;
  assign sif_b.move  = sel ? drv_move  : 1'b0;

  sprite_mover #(.X_MAX(160), .Y_MAX(120), .BOX(BOX), .TICK_DIV(TD),
                 .X_INIT(10), .Y_INIT(20), .COLOUR(3'b111)) u_dut_a (
    .clk(clk), .resetn(resetn), .bus(sif_a));

  sprite_mover #(.X_MAX(16), .Y_MAX(16), .BOX(BOX), .TICK_DIV(TD),
                 .X_INIT(0), .Y_INIT(0), .COLOUR(3'b111)) u_dut_b (
    .clk(clk), .resetn(resetn), .bus(sif_b));

  // {plot, busy, stop, colour, x, y}
  logic [20:0] mon_a, mon_b, mon;
  assign mon_a = {sif_a.plot, sif_a.busy, sif_a.stop, sif_a.colour, sif_a.x_out, sif_a.y_out};
  assign mon_b = {sif_b.plot, sif_b.busy, sif_b.stop, sif_b.colour, sif_b.x_out, sif_b.y_out};
  assign mon   = sel ? mon_b : mon_a;

  int checks = 0;
  int errors = 0;
  int mpx, mpy;
  bit mdx, mdy;

  function automatic int xmax();  return sel ? 16 : 160; endfunction
  function automatic int ymax();  return sel ? 16 : 120; endfunction
  function automatic int xinit(); return sel ? 0 : 10;   endfunction
  function automatic int yinit(); return sel ? 0 : 20;   endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reload();
    mpx = xinit(); mpy = yinit(); mdx = 1'b1; mdy = 1'b1;
  endtask

  task automatic model_update(output bit floor);
    bit ody;
    ody = mdy;
    if ((mdx && mpx == xmax() - BOX) || (!mdx && mpx == 0)) mdx = !mdx;
    if ((mdy && mpy == ymax() - BOX) || (!mdy && mpy == 0)) mdy = !mdy;
    mpx = mdx ? mpx + 1 : mpx - 1;
    mpy = mdy ? mpy + 1 : mpy - 1;
    floor = ody && (mpy == ymax() - BOX);
  endtask

  // Drive move (held or random) until TD move cycles accumulate; plot must rise exactly then.
  task automatic wait_first_pixel(input bit rand_move);
    int  moves;
    bit  done;
    logic exp_p;
    moves = 0;
    done  = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      drv_move = rand_move ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (drv_move) moves++;
      exp_p = (moves == TD);
      checks++;
      if (mon[20:18] !== {exp_p, exp_p, 1'b0}) begin
        errors++;
        $display("FAIL tick_wait got %b want %b (moves %0d)", mon[20:18], {exp_p, exp_p, 1'b0}, moves);
      end
      if (exp_p || mon[20]) done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("FAIL tick_wait_timeout got no plot want plot");
    end
  endtask

  // Checks one full step starting at the first visible erase pixel.
  // mode: 0 leave move alone, 1 randomise move each cycle, 2 drop move during erase.
  task automatic run_step(input int mode);
    logic [20:0] exp;
    logic        stop_e;
    bit          floor;
    for (int i = 0; i < BOX * BOX; i++) begin
      if (mode == 1) drv_move = 1'($urandom_range(0, 1));
      else if (mode == 2 && i == 2) drv_move = 1'b0;
      exp = {3'b110, 3'b000, 8'(mpx + i % BOX), 7'(mpy + i / BOX)};
      checks++;
      if (mon !== exp) begin
        errors++;
        $display("FAIL erase_px%0d got %h want %h", i, mon, exp);
      end
      tick();
    end
    checks++;
    if (mon[20:18] !== 3'b010) begin
      errors++;
      $display("FAIL update_cycle got %b want 010", mon[20:18]);
    end
    model_update(floor);
    tick();
    for (int i = 0; i < BOX * BOX; i++) begin
      if (mode == 1) drv_move = 1'($urandom_range(0, 1));
      stop_e = (i == 0) && floor;
      exp = {2'b11, stop_e, 3'b111, 8'(mpx + i % BOX), 7'(mpy + i / BOX)};
      checks++;
      if (mon !== exp) begin
        errors++;
        $display("FAIL draw_px%0d got %h want %h", i, mon, exp);
      end
      tick();
    end
    checks++;
    if (mon[20:18] !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_step got %b want 000", mon[20:18]);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; drv_start = 1'b0; drv_move = 1'b0; sel = 1'b0;
    tick(); tick();
    checks++;
    if ({mon_a, mon_b} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {mon_a, mon_b});
    end
    resetn = 1'b1;
    tick();
    checks++;
    if (mon_a[20:18] !== 3'b000) begin
      errors++;
      $display("FAIL reset_release got %b want 000", mon_a[20:18]);
    end
    mpx = 0; mpy = 0; mdx = 1'b1; mdy = 1'b1;
  endtask

  task automatic test_reload();
    drv_start = 1'b1;
    tick();
    drv_start = 1'b0;
    model_reload();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (mon[20:18] !== 3'b000) begin
        errors++;
        $display("FAIL reload_no_plot got %b want 000", mon[20:18]);
      end
    end
  endtask

  task automatic test_single_step();
    wait_first_pixel(1'b0);
    run_step(0);
  endtask

  task automatic test_bounce_floor();
    for (int s = 0; s < 160; s++) begin
      wait_first_pixel(1'b1);
      run_step(1);
    end
  endtask

  task automatic test_priority();
    drv_move = 1'b1;
    tick();
    tick();
    checks++;
    if (mon[20] !== 1'b0) begin
      errors++;
      $display("FAIL priority_pre got plot %b want 0", mon[20]);
    end
    drv_start = 1'b1;
    drv_move  = 1'b1;
    tick();
    drv_start = 1'b0;
    model_reload();
    wait_first_pixel(1'b0);
    run_step(0);
  endtask

  task automatic test_move_drop();
    wait_first_pixel(1'b0);
    run_step(2);
    for (int i = 0; i < 3 * TD + 4; i++) begin
      tick();
      checks++;
      if (mon[20:18] !== 3'b000) begin
        errors++;
        $display("FAIL move_drop_idle got %b want 000", mon[20:18]);
      end
    end
  endtask

  task automatic test_reset_mid_draw();
    wait_first_pixel(1'b0);
    for (int i = 0; i < BOX * BOX + 4; i++) tick();
    resetn = 1'b0;
    tick();
    resetn   = 1'b1;
    drv_move = 1'b0;
    checks++;
    if (mon !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_draw got %h want 0", mon);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mon[20:18] !== 3'b000) begin
        errors++;
        $display("FAIL after_reset_idle got %b want 000", mon[20:18]);
      end
    end
    test_reload();
    wait_first_pixel(1'b0);
    run_step(0);
  endtask

  task automatic test_corner();
    sel = 1'b1;
    drv_move = 1'b0;
    test_reload();
    for (int s = 0; s < 26; s++) begin
      wait_first_pixel(1'b1);
      run_step(1);
    end
  endtask

  initial begin
    test_reset();
    test_reload();
    test_single_step();
    test_bounce_floor();
    test_priority();
    test_move_drop();
    test_reset_mid_draw();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
